// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, constants and the packed operand layout.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

endpackage

// File: rtl/fp16_multiply_if.sv
// Operand/result bundle between the datapath producer and the fp16 multiplier.
interface fp16_multiply_if;
    logic [15:0] in_A;
    logic [15:0] in_B;
    logic        in_En;
    logic [15:0] out_Out;
    logic        out_Ready;

    modport master (output in_A, in_B, in_En, input  out_Out, out_Ready);
    modport slave  (input  in_A, in_B, in_En, output out_Out, out_Ready);
endinterface

// File: rtl/fp16_classify.sv
// Decodes one binary16 operand into zero/inf/nan flags and its 11-bit significand.
// Latency: combinational.
// Backpressure: none, pure decode.
module fp16_classify
    import fp16_pkg::*;
(
    input  fp16_t        op,
    output logic         is_zero,
    output logic         is_inf,
    output logic         is_nan,
    output logic [10:0]  sig
);
    // Subnormals are folded into zero, so the hidden bit is always 1 on the normal path.
    assign is_zero = (op.exp == '0);
    assign is_inf  = (op.exp == '1) && (op.frac == '0);
    assign is_nan  = (op.exp == '1) && (op.frac != '0);
    assign sig     = {1'b1, op.frac};
endmodule

// File: rtl/fp16_multiply.sv
// binary16 multiplier: RNE rounding, flush-to-zero in and out, registered result.
// Latency: 1 clock from in_En to out_Ready/out_Out.
// Backpressure: none; out_Ready is a one-cycle pulse the consumer must take.
module fp16_multiply
    import fp16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fp16_multiply_if.slave   bus
);
    localparam logic signed [6:0] BIAS_S = 7'(BIAS);

    fp16_t       fa, fb;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic [10:0] sig_a, sig_b;

    assign fa = fp16_t'(bus.in_A);
    assign fb = fp16_t'(bus.in_B);

    fp16_classify u_cls_a (.op(fa), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .sig(sig_a));
    fp16_classify u_cls_b (.op(fb), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .sig(sig_b));

    logic [21:0]        prod;
    logic signed [6:0]  exp_base, exp_norm, exp_fin;
    logic [9:0]         mant;
    logic               guard, rnd, sticky, round_up, sign;
    logic [10:0]        mant_rnd;
    logic [15:0]        result;

    assign exp_base = signed'({2'b00, fa.exp}) + signed'({2'b00, fb.exp}) - BIAS_S;

    always_comb begin
        prod     = 22'(sig_a) * 22'(sig_b);
        exp_norm = exp_base + 7'(prod[21]);
        if (prod[21]) begin
            mant   = prod[20:11];
            guard  = prod[10];
            rnd    = prod[9];
            sticky = |prod[8:0];
        end else begin
            mant   = prod[19:10];
            guard  = prod[9];
            rnd    = prod[8];
            sticky = |prod[7:0];
        end
        round_up = guard & (rnd | sticky | mant[0]);
        mant_rnd = {1'b0, mant} + 11'(round_up);
        // On carry-out the low ten bits are already zero, i.e. 1.0 at the next exponent.
        exp_fin  = exp_norm + 7'(mant_rnd[10]);
        sign     = fa.sign ^ fb.sign;

        if (a_nan || b_nan)
            result = FP16_QNAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            result = FP16_QNAN;
        else if (a_inf || b_inf)
            result = {sign, FP16_POS_INF[14:0]};
        else if (a_zero || b_zero)
            result = {sign, 15'h0000};
        else if (exp_fin >= 7'sd31)
            result = {sign, FP16_POS_INF[14:0]};
        else if (exp_fin <= 7'sd0)
            result = {sign, 15'h0000};
        else
            result = {sign, exp_fin[4:0], mant_rnd[9:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_Out   <= 16'h0000;
            bus.out_Ready <= 1'b0;
        end else begin
            bus.out_Ready <= bus.in_En;
            if (bus.in_En)
                bus.out_Out <= result;
        end
    end
endmodule

// File: tb/tb_fp16_multiply.sv
// Scoreboard bench for fp16_multiply: directed vectors plus random operands vs a real-arithmetic model.
module tb_fp16_multiply;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fp16_multiply_if bif();
    fp16_multiply dut (.clk(clk), .rst(rst), .bus(bif));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else        repeat (-n) r = r / 2.0;
        return r;
    endfunction

    // Exact real product, then round-to-nearest-even onto the binary16 normal grid.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int ea, eb, fa, fb, e, mi;
        bit za, zb, ia, ib, na, nb;
        real x, m, fl, r;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]); fa = int'(a[9:0]);
        eb = int'(b[14:10]); fb = int'(b[9:0]);
        na = (ea == 31) && (fa != 0);  nb = (eb == 31) && (fb != 0);
        ia = (ea == 31) && (fa == 0);  ib = (eb == 31) && (fb == 0);
        za = (ea == 0);                zb = (eb == 0);
        if (na || nb) return 16'h7E00;
        if ((ia && zb) || (ib && za)) return 16'h7E00;
        if (ia || ib) return {s, 15'h7C00};
        if (za || zb) return {s, 15'h0000};
        x = (real'(1024 + fa) * pow2(ea - 25)) * (real'(1024 + fb) * pow2(eb - 25));
        e = 0;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        m  = x * 1024.0;
        fl = $floor(m);
        r  = m - fl;
        mi = int'(fl);
        if (r > 0.5 || (r == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 2048) begin mi = 1024; e++; end
        if (e + 15 >= 31) return {s, 15'h7C00};
        if (e + 15 <= 0)  return {s, 15'h0000};
        return {s, 5'(e + 15), 10'(mi - 1024)};
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] req);
        @(negedge clk);
        bif.in_A  = a;
        bif.in_B  = b;
        bif.in_En = 1'b1;
        exp_q.push_back(req);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bif.in_En = 1'b0;
            bif.in_A  = 16'($urandom());
            bif.in_B  = 16'($urandom());
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always begin
        @(posedge clk);
        #1;
        if (bif.out_Ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got out_Out %h with no pending request", bif.out_Out);
            end else begin
                check("product", bif.out_Out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation exceeded time bound");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] r; } vec_t;
    vec_t dir[$] = '{
        '{16'h3C00, 16'h4000, 16'h4000}, '{16'h3E00, 16'h3E00, 16'h4080},
        '{16'h7BFF, 16'h4000, 16'h7C00}, '{16'h0400, 16'h0400, 16'h0000},
        '{16'h8400, 16'h0400, 16'h8000}, '{16'h7C00, 16'h0000, 16'h7E00},
        '{16'h7E00, 16'h3C00, 16'h7E00}, '{16'hFC00, 16'h4000, 16'hFC00},
        '{16'h0001, 16'h3C00, 16'h0000}
    };

    initial begin
        logic [15:0] ra, rb;
        bif.in_A = 16'h0; bif.in_B = 16'h0; bif.in_En = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", bif.out_Out, 16'h0000);
        check("reset_ready", 16'(bif.out_Ready), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        issue(16'h57B7, 16'hD7B7, 16'hF371);
        idle(1);
        @(posedge clk); #2;
        check("hold_ready", 16'(bif.out_Ready), 16'h0000);
        check("hold_out", bif.out_Out, 16'hF371);

        foreach (dir[i]) begin
            issue(dir[i].a, dir[i].b, dir[i].r);
            idle(1);
        end

        // Three back-to-back products with ready held high throughout.
        issue(16'h4200, 16'h4500, 16'h4B80);
        issue(16'hBC00, 16'h3555, 16'hB555);
        issue(16'h3C01, 16'h3C01, 16'h3C02);
        @(posedge clk); #2;
        check("b2b_ready3", 16'(bif.out_Ready), 16'h0001);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            if (i < 150) begin
                ra = {1'($urandom()), 5'($urandom_range(5, 26)), 10'($urandom())};
                rb = {1'($urandom()), 5'($urandom_range(5, 26)), 10'($urandom())};
            end else begin
                ra = 16'($urandom());
                rb = 16'($urandom());
            end
            issue(ra, rb, ref_mul(ra, rb));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);

        // Async reset between edges, with an enable pending that must be lost.
        issue(16'h3C00, 16'h4000, 16'h4000);
        @(negedge clk);
        bif.in_A = 16'h4000; bif.in_B = 16'h4000; bif.in_En = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("arst_out", bif.out_Out, 16'h0000);
        check("arst_ready", 16'(bif.out_Ready), 16'h0000);
        @(posedge clk); #2;
        check("arst_lost_ready", 16'(bif.out_Ready), 16'h0000);
        @(negedge clk);
        bif.in_En = 1'b0;
        rst = 1'b0;

        repeat (4) @(posedge clk);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
